// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common-data-bus arbiter for NUM_FU functional-unit result ports.
// Each FU owns a one-deep holding entry (full flag, data, ROB index). Every
// cycle one full entry is granted and its contents are registered onto the
// CDB outputs; a granted entry may be refilled on the same edge, which lets a
// single uncontended FU stream one result per cycle.
//
// Optional build macro:
//   CDB_FIXED_PRIO_EN - lowest-index full entry always wins and the
//                       round-robin pointer is removed. When undefined the
//                       grant rotates, starting at rr_ptr_q.
module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int DATA_W    = 32,
    parameter int ROB_IDX_W = 3,
    localparam int SRC_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        flush_in,
    input  logic [NUM_FU-1:0]           fu_valid_in,
    input  logic [NUM_FU*DATA_W-1:0]    fu_data_in,
    input  logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_idx_in,
    output logic [NUM_FU-1:0]           fu_ready_out,
    output logic                        cdb_valid_out,
    output logic [DATA_W-1:0]           cdb_data_out,
    output logic [ROB_IDX_W-1:0]        cdb_rob_idx_out,
    output logic [SRC_W-1:0]            cdb_src_out
);

    // Holding entries
    logic [NUM_FU-1:0]    full_q;
    logic [NUM_FU-1:0]    full_d;
    logic [DATA_W-1:0]    data_q [NUM_FU];
    logic [ROB_IDX_W-1:0] rob_q  [NUM_FU];

    // Arbitration results
    logic [NUM_FU-1:0]    grant;
    logic                 grant_any;
    logic [SRC_W-1:0]     grant_idx;
    logic [NUM_FU-1:0]    capture;

    // Registered CDB
    logic                 cdb_valid_q;
    logic [DATA_W-1:0]    cdb_data_q;
    logic [ROB_IDX_W-1:0] cdb_rob_q;
    logic [SRC_W-1:0]     cdb_src_q;

    // An entry can accept when empty, or when it is being drained this cycle.
    // A flush blocks all acceptance so nothing survives the discard.
    assign fu_ready_out = flush_in ? '0 : (~full_q | grant);
    assign capture      = fu_valid_in & fu_ready_out;

`ifdef CDB_FIXED_PRIO_EN

    // Fixed priority: lowest-index full entry wins.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!grant_any && full_q[k]) begin
                grant[k]  = 1'b1;
                grant_any = 1'b1;
                grant_idx = SRC_W'(k);
            end
        end
    end

`else

    logic [SRC_W-1:0] rr_ptr_q;
    logic [SRC_W-1:0] cand;

    // Entry index base+off, wrapped modulo NUM_FU (off < NUM_FU).
    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base,
                                                  input int               off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_FU) begin
            sum = sum - NUM_FU;
        end
        return SRC_W'(sum);
    endfunction

    // Round robin: first full entry at or after rr_ptr_q, wrapping.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            cand = wrap_add(rr_ptr_q, k);
            if (!grant_any && full_q[cand]) begin
                grant[cand] = 1'b1;
                grant_any   = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Pointer moves just past the winner; idle and flush edges leave it alone.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr_q <= '0;
        end else if (!flush_in && grant_any) begin
            if (grant_idx == SRC_W'(NUM_FU - 1)) begin
                rr_ptr_q <= '0;
            end else begin
                rr_ptr_q <= grant_idx + 1'b1;
            end
        end
    end

`endif

    // Per-entry full flag: flush clears, capture sets (wins over drain), grant clears.
    generate
        for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_entry
            assign full_d[gi] = flush_in     ? 1'b0 :
                                capture[gi]  ? 1'b1 :
                                grant[gi]    ? 1'b0 :
                                full_q[gi];
        end
    endgenerate

    // Entry payload storage; only meaningful while the matching full flag is set.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (capture[i]) begin
                data_q[i] <= fu_data_in[i*DATA_W +: DATA_W];
                rob_q[i]  <= fu_rob_idx_in[i*ROB_IDX_W +: ROB_IDX_W];
            end
        end
    end

    // Full flags and the registered broadcast; payload holds when nothing is granted.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            full_q      <= '0;
            cdb_valid_q <= 1'b0;
            cdb_data_q  <= '0;
            cdb_rob_q   <= '0;
            cdb_src_q   <= '0;
        end else begin
            full_q <= full_d;
            if (flush_in) begin
                cdb_valid_q <= 1'b0;
            end else if (grant_any) begin
                cdb_valid_q <= 1'b1;
                cdb_data_q  <= data_q[grant_idx];
                cdb_rob_q   <= rob_q[grant_idx];
                cdb_src_q   <= grant_idx;
            end else begin
                cdb_valid_q <= 1'b0;
            end
        end
    end

    assign cdb_valid_out   = cdb_valid_q;
    assign cdb_data_out    = cdb_data_q;
    assign cdb_rob_idx_out = cdb_rob_q;
    assign cdb_src_out     = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter (default parameters).
// Expected values are hand-derived; arbitration-order expectations follow
// CDB_FIXED_PRIO_EN when the bench is built with it.
module tb_cdb_arbiter;

    localparam int NUM_FU    = 4;
    localparam int DATA_W    = 32;
    localparam int ROB_IDX_W = 3;
    localparam int SRC_W     = 2;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        flush = 1'b0;
    logic [NUM_FU-1:0]           fu_valid = '0;
    logic [NUM_FU*DATA_W-1:0]    fu_data = '0;
    logic [NUM_FU*ROB_IDX_W-1:0] fu_rob = '0;
    logic [NUM_FU-1:0]           fu_ready;
    logic                        cdb_valid;
    logic [DATA_W-1:0]           cdb_data;
    logic [ROB_IDX_W-1:0]        cdb_rob;
    logic [SRC_W-1:0]            cdb_src;

    int n_tests = 0;
    int n_fail  = 0;

    cdb_arbiter #(
        .NUM_FU    (NUM_FU),
        .DATA_W    (DATA_W),
        .ROB_IDX_W (ROB_IDX_W)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .flush_in        (flush),
        .fu_valid_in     (fu_valid),
        .fu_data_in      (fu_data),
        .fu_rob_idx_in   (fu_rob),
        .fu_ready_out    (fu_ready),
        .cdb_valid_out   (cdb_valid),
        .cdb_data_out    (cdb_data),
        .cdb_rob_idx_out (cdb_rob),
        .cdb_src_out     (cdb_src)
    );

    always #5 clk = ~clk;

    task automatic set_fu(input int i, input logic v, input logic [31:0] d, input logic [2:0] r);
        fu_valid[i]         = v;
        fu_data[i*32 +: 32] = d;
        fu_rob[i*3 +: 3]    = r;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        fu_valid = '0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n    = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        n_tests++;
        if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", cdb_valid); end
        n_tests++;
        if (cdb_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", cdb_data); end
        n_tests++;
        if (cdb_rob !== 3'd0) begin n_fail++; $display("FAIL reset_rob: got %0d expected 0", cdb_rob); end
        n_tests++;
        if (cdb_src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d expected 0", cdb_src); end
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (fu_ready !== 4'hF) begin n_fail++; $display("FAIL reset_ready: got %b expected 1111", fu_ready); end
        $display("[TB] reset done");
    endtask

    task automatic test_single;
        do_reset();
        set_fu(1, 1'b1, 32'h0000_00AB, 3'd5);
        tick();                                   // E0: accepted
        set_fu(1, 1'b0, 32'h0, 3'd0);
        n_tests++;
        if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got valid %0b expected 0", cdb_valid); end
        tick();                                   // E1: broadcast
        $display("[TB] single: valid=%0b src=%0d rob=%0d data=%h", cdb_valid, cdb_src, cdb_rob, cdb_data);
        n_tests++;
        if (cdb_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b expected 1", cdb_valid); end
        n_tests++;
        if (cdb_data !== 32'hAB) begin n_fail++; $display("FAIL single_data: got %h expected 000000ab", cdb_data); end
        n_tests++;
        if (cdb_rob !== 3'd5) begin n_fail++; $display("FAIL single_rob: got %0d expected 5", cdb_rob); end
        n_tests++;
        if (cdb_src !== 2'd1) begin n_fail++; $display("FAIL single_src: got %0d expected 1", cdb_src); end
        tick();
        n_tests++;
        if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: got valid %0b expected 0", cdb_valid); end
        n_tests++;
        if (cdb_data !== 32'hAB) begin n_fail++; $display("FAIL single_hold: got %h expected 000000ab", cdb_data); end
    endtask

    task automatic test_contention;
        int          exp_src  [5];
        logic [31:0] exp_data [5];
        logic [2:0]  exp_rob  [5];
`ifdef CDB_FIXED_PRIO_EN
        exp_src  = '{0, 0, 1, 2, 3};
        exp_data = '{32'h100, 32'h200, 32'h101, 32'h102, 32'h103};
        exp_rob  = '{3'd0, 3'd7, 3'd1, 3'd2, 3'd3};
`else
        exp_src  = '{0, 1, 2, 3, 0};
        exp_data = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h200};
        exp_rob  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7};
`endif
        do_reset();
        for (int i = 0; i < 4; i++) set_fu(i, 1'b1, 32'h100 + i, 3'(i));
        tick();                                   // E0: all four accepted
        for (int i = 1; i < 4; i++) set_fu(i, 1'b0, 32'h0, 3'd0);
        set_fu(0, 1'b1, 32'h200, 3'd7);
        #1;
        n_tests++;
        if (fu_ready !== 4'b0001) begin n_fail++; $display("FAIL cont_ready: got %b expected 0001", fu_ready); end
        tick();                                   // E1: FU0 granted and refilled
        set_fu(0, 1'b0, 32'h0, 3'd0);
        for (int j = 0; j < 5; j++) begin
            if (j > 0) tick();
            $display("[TB] contention bcast %0d: valid=%0b src=%0d rob=%0d data=%h", j, cdb_valid, cdb_src, cdb_rob, cdb_data);
            n_tests++;
            if (cdb_valid !== 1'b1) begin n_fail++; $display("FAIL cont_valid[%0d]: got %0b expected 1", j, cdb_valid); end
            n_tests++;
            if (cdb_src !== 2'(exp_src[j])) begin n_fail++; $display("FAIL cont_src[%0d]: got %0d expected %0d", j, cdb_src, exp_src[j]); end
            n_tests++;
            if (cdb_data !== exp_data[j] || cdb_rob !== exp_rob[j]) begin
                n_fail++;
                $display("FAIL cont_payload[%0d]: got %h/%0d expected %h/%0d", j, cdb_data, cdb_rob, exp_data[j], exp_rob[j]);
            end
        end
        tick();
        n_tests++;
        if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL cont_drained: got valid %0b expected 0", cdb_valid); end
    endtask

    task automatic test_back_to_back;
        int n_bc;
        n_bc = 0;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            set_fu(2, 1'b1, 32'(k), 3'(k));
            #1;
            n_tests++;
            if (fu_ready[2] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %0b expected 1", k, fu_ready[2]); end
            tick();
            if (k >= 2) begin
                if (cdb_valid === 1'b1) n_bc++;
                n_tests++;
                if (cdb_valid !== 1'b1 || cdb_data !== 32'(k - 1)) begin
                    n_fail++;
                    $display("FAIL b2b_bcast[%0d]: got valid %0b data %0d expected valid 1 data %0d", k - 1, cdb_valid, cdb_data, k - 1);
                end
            end else begin
                n_tests++;
                if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_latency: got valid %0b expected 0", cdb_valid); end
            end
        end
        set_fu(2, 1'b0, 32'h0, 3'd0);
        tick();
        if (cdb_valid === 1'b1) n_bc++;
        n_tests++;
        if (cdb_valid !== 1'b1 || cdb_data !== 32'd8) begin
            n_fail++;
            $display("FAIL b2b_last: got valid %0b data %0d expected valid 1 data 8", cdb_valid, cdb_data);
        end
        tick();
        n_tests++;
        if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_extra: got valid %0b expected 0", cdb_valid); end
        $display("[TB] back_to_back: %0d broadcasts", n_bc);
        n_tests++;
        if (n_bc !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", n_bc); end
    endtask

    task automatic test_backpressure;
        logic [31:0] q0 [2];
        logic [31:0] q1 [2];
        logic [31:0] exp_data [4];
        int          exp_src  [4];
        logic [31:0] got_data [$];
        int          got_src  [$];
        int          p0, p1;
        logic        acc0, acc1;
        q0 = '{32'hA0, 32'hA1};
        q1 = '{32'hB0, 32'hB1};
`ifdef CDB_FIXED_PRIO_EN
        exp_data = '{32'hA0, 32'hA1, 32'hB0, 32'hB1};
        exp_src  = '{0, 0, 1, 1};
`else
        exp_data = '{32'hA0, 32'hB0, 32'hA1, 32'hB1};
        exp_src  = '{0, 1, 0, 1};
`endif
        p0 = 0;
        p1 = 0;
        do_reset();
        for (int cyc = 0; cyc < 10; cyc++) begin
            set_fu(0, p0 < 2, (p0 < 2) ? q0[p0] : 32'h0, 3'd0);
            set_fu(1, p1 < 2, (p1 < 2) ? q1[p1] : 32'h0, 3'd1);
            #1;
            acc0 = fu_valid[0] && fu_ready[0];
            acc1 = fu_valid[1] && fu_ready[1];
            if (cyc == 1) begin
                n_tests++;
                if (fu_ready[1:0] !== 2'b01) begin n_fail++; $display("FAIL bp_ready_drop: got %b expected 01", fu_ready[1:0]); end
            end
            tick();
            if (acc0) p0++;
            if (acc1) p1++;
            if (cdb_valid === 1'b1) begin
                $display("[TB] backpressure bcast: src=%0d data=%h", cdb_src, cdb_data);
                got_data.push_back(cdb_data);
                got_src.push_back(int'(cdb_src));
            end
        end
        n_tests++;
        if (got_data.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", got_data.size()); end
        for (int j = 0; j < 4 && j < got_data.size(); j++) begin
            n_tests++;
            if (got_data[j] !== exp_data[j] || got_src[j] != exp_src[j]) begin
                n_fail++;
                $display("FAIL bp_order[%0d]: got src %0d data %h expected src %0d data %h", j, got_src[j], got_data[j], exp_src[j], exp_data[j]);
            end
        end
    endtask

    task automatic test_flush;
        do_reset();
        set_fu(0, 1'b1, 32'h11, 3'd1);
        set_fu(3, 1'b1, 32'h33, 3'd3);
        tick();                                   // E0: entries 0 and 3 full
        set_fu(0, 1'b0, 32'h0, 3'd0);
        set_fu(3, 1'b0, 32'h0, 3'd0);
        flush = 1'b1;
        #1;
        n_tests++;
        if (fu_ready !== 4'b0000) begin n_fail++; $display("FAIL flush_ready: got %b expected 0000", fu_ready); end
        tick();                                   // flush edge
        flush = 1'b0;
        #1;
        n_tests++;
        if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b expected 0", cdb_valid); end
        n_tests++;
        if (fu_ready !== 4'hF) begin n_fail++; $display("FAIL flush_empty: got %b expected 1111", fu_ready); end
        for (int j = 0; j < 3; j++) begin
            tick();
            n_tests++;
            if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_late_bcast[%0d]: got valid %0b src %0d", j, cdb_valid, cdb_src); end
        end
        $display("[TB] flush done");
    endtask

    task automatic test_async_reset;
        do_reset();
        for (int i = 0; i < 4; i++) set_fu(i, 1'b1, 32'h40 + i, 3'(i));
        tick();                                   // E0: all four accepted
        fu_valid = '0;
        tick();                                   // E1: FU0 broadcast, three still full
        n_tests++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'd0) begin
            n_fail++;
            $display("FAIL arst_setup: got valid %0b src %0d expected valid 1 src 0", cdb_valid, cdb_src);
        end
        #3;
        rst_n = 1'b0;                             // mid-cycle, no clock edge
        #1;
        n_tests++;
        if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0b expected 0", cdb_valid); end
        n_tests++;
        if (cdb_data !== 32'h0 || cdb_src !== 2'd0) begin
            n_fail++;
            $display("FAIL arst_clear: got data %h src %0d expected 0/0", cdb_data, cdb_src);
        end
        n_tests++;
        if (fu_ready !== 4'hF) begin n_fail++; $display("FAIL arst_ready: got %b expected 1111", fu_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            n_tests++;
            if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL arst_stale[%0d]: got valid %0b src %0d", j, cdb_valid, cdb_src); end
        end
        set_fu(0, 1'b1, 32'h50, 3'd0);
        set_fu(3, 1'b1, 32'h53, 3'd3);
        tick();
        fu_valid = '0;
        tick();
        $display("[TB] arst arrival 1: src=%0d data=%h", cdb_src, cdb_data);
        n_tests++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_data !== 32'h50) begin
            n_fail++;
            $display("FAIL arst_first: got valid %0b src %0d data %h expected 1/0/00000050", cdb_valid, cdb_src, cdb_data);
        end
        tick();
        $display("[TB] arst arrival 2: src=%0d data=%h", cdb_src, cdb_data);
        n_tests++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'd3 || cdb_data !== 32'h53) begin
            n_fail++;
            $display("FAIL arst_second: got valid %0b src %0d data %h expected 1/3/00000053", cdb_valid, cdb_src, cdb_data);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
